// File: rtl/motor_pkg.sv
// Types and default widths shared between the step/dir generator and the
// receive-side step_pulse_monitor.
package motor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_ARMED = 2'd1,
        MON_RUN   = 2'd2,
        MON_STALL = 2'd3
    } mon_state_t;

    localparam int POS_W           = 32;
    localparam int DEF_PERIOD_W    = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_HIGH    = 2;

endpackage

// File: rtl/pulse_sync_filter.sv
// Synchronises the step/dir pair and turns each sufficiently long step pulse
// into a single-cycle step_evt strobe carrying the sampled direction.
module pulse_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pul_in,
    input  logic dir_in,
    output logic step_evt,
    output logic dir
);

    localparam int CNT_W = (MIN_HIGH < 2) ? 1 : $clog2(MIN_HIGH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MIN_HIGH);

    logic [SYNC_STAGES-1:0] pul_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       lo_cnt;
    logic                   disarmed;
    logic                   pul_s;

    assign pul_s = pul_sync[SYNC_STAGES-1];
    assign dir   = dir_sync[SYNC_STAGES-1];

    // hi_cnt/lo_cnt hold the number of earlier consecutive cycles at the
    // current level, so the MIN_HIGH-th high cycle is the one that fires.
    assign step_evt = pul_s && !disarmed && (hi_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pul_sync <= '0;
            dir_sync <= '0;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            disarmed <= 1'b0;
        end else begin
            pul_sync <= {pul_sync[SYNC_STAGES-2:0], pul_in};
            dir_sync <= {dir_sync[SYNC_STAGES-2:0], dir_in};
            if (pul_s) begin
                lo_cnt <= '0;
                if (hi_cnt != CNT_SAT)
                    hi_cnt <= hi_cnt + 1'b1;
                if (step_evt)
                    disarmed <= 1'b1;
            end else begin
                hi_cnt <= '0;
                if (lo_cnt == CNT_LAST)
                    disarmed <= 1'b0;
                else
                    lo_cnt <= lo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_pulse_monitor.sv
// Receive-side step/dir monitor: tracks position and step count, measures the
// clock period between accepted steps and flags stall/completion.
module step_pulse_monitor
    import motor_pkg::*;
#(
    parameter int                  SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int                  MIN_HIGH    = DEF_MIN_HIGH,
    parameter int                  PERIOD_W    = DEF_PERIOD_W,
    parameter logic [PERIOD_W-1:0] TIMEOUT     = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pul_in,
    input  logic                       dir_in,
    input  logic                       en,
    input  logic                       pos_clr,
    input  logic [POS_W-1:0]           target,
    input  logic                       period_ready,
    output logic signed [POS_W-1:0]    step_pos,
    output logic [POS_W-1:0]           step_cnt,
    output logic [PERIOD_W-1:0]        period_data,
    output logic                       period_valid,
    output logic                       period_ovf,
    output logic                       stall,
    output logic                       done,
    output logic [1:0]                 mon_state
);

    mon_state_t          state, state_nxt;
    logic                step_evt;
    logic                dir;
    logic [PERIOD_W-1:0] period_cnt;
    logic [POS_W-1:0]    cnt_inc;
    logic                arm_clr;
    logic                step_acc;
    logic                new_sample;

    pulse_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_HIGH    (MIN_HIGH)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .pul_in   (pul_in),
        .dir_in   (dir_in),
        .step_evt (step_evt),
        .dir      (dir)
    );

    assign arm_clr    = en && (state == MON_IDLE);
    assign step_acc   = en && step_evt && (state != MON_IDLE);
    assign new_sample = en && step_evt && (state == MON_RUN);
    assign cnt_inc    = step_cnt + 1'b1;
    assign mon_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= MON_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = MON_IDLE;
        end else begin
            unique case (state)
                MON_IDLE:  state_nxt = MON_ARMED;
                MON_ARMED: if (step_evt) state_nxt = MON_RUN;
                MON_RUN:   if (!step_evt && period_cnt == TIMEOUT) state_nxt = MON_STALL;
                MON_STALL: if (step_evt) state_nxt = MON_RUN;
                default:   state_nxt = MON_IDLE;
            endcase
        end
    end

    // Position follows the pulse stream independently of en and the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_pos <= '0;
        else if (pos_clr)
            step_pos <= '0;
        else if (step_evt)
            step_pos <= dir ? step_pos + 1 : step_pos - 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt   <= '0;
            period_cnt <= '0;
            stall      <= 1'b0;
            done       <= 1'b0;
        end else begin
            stall <= (state_nxt == MON_STALL);
            if (!en) begin
                done <= 1'b0;
            end else if (arm_clr) begin
                step_cnt   <= '0;
                period_cnt <= '0;
                done       <= 1'b0;
            end else if (step_acc) begin
                step_cnt   <= cnt_inc;
                period_cnt <= PERIOD_W'(1);
                if (target != '0 && cnt_inc == target)
                    done <= 1'b1;
            end else if (state == MON_RUN && period_cnt != '1) begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

    // Single-entry output slot: a sample arriving while the slot is full and
    // not being drained is dropped and remembered in period_ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_data  <= '0;
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
        end else if (arm_clr) begin
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
        end else if (new_sample) begin
            if (!period_valid || period_ready) begin
                period_data  <= period_cnt;
                period_valid <= 1'b1;
            end else begin
                period_ovf <= 1'b1;
            end
        end else if (period_ready) begin
            period_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Directed bench for step_pulse_monitor with hand-computed expectations.
module tb_step_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pul_in;
    logic        dir_in;
    logic        en;
    logic        pos_clr;
    logic [31:0] target;
    logic        period_ready;
    logic [31:0] step_pos;
    logic [31:0] step_cnt;
    logic [15:0] period_data;
    logic        period_valid;
    logic        period_ovf;
    logic        stall;
    logic        done;
    logic [1:0]  mon_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_samp   = 0;
    int          samp0;
    logic [15:0] exp_period = 16'd0;

    always #5 clk = ~clk;

    step_pulse_monitor #(
        .SYNC_STAGES (2),
        .MIN_HIGH    (2),
        .PERIOD_W    (16),
        .TIMEOUT     (16'd50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pul_in       (pul_in),
        .dir_in       (dir_in),
        .en           (en),
        .pos_clr      (pos_clr),
        .target       (target),
        .period_ready (period_ready),
        .step_pos     (step_pos),
        .step_cnt     (step_cnt),
        .period_data  (period_data),
        .period_valid (period_valid),
        .period_ovf   (period_ovf),
        .stall        (stall),
        .done         (done),
        .mon_state    (mon_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo, input logic d);
        dir_in = d;
        pul_in = 1'b1;
        repeat (hi) tick();
        pul_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos"},   step_pos, 32'd0);
        check({tag, "_cnt"},   step_cnt, 32'd0);
        check({tag, "_pdata"}, 32'(period_data), 32'd0);
        check({tag, "_pvld"},  32'(period_valid), 32'd0);
        check({tag, "_povf"},  32'(period_ovf), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_state"}, 32'(mon_state), 32'd0);
    endtask

    // Every accepted handshake must carry the period the stimulus implies.
    always @(posedge clk) begin
        if (rst_n && period_valid && period_ready) begin
            n_samp++;
            check("sample_data", 32'(period_data), 32'(exp_period));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pul_in = 1'b0; dir_in = 1'b0; en = 1'b0;
        pos_clr = 1'b0; target = 32'd0; period_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_state", 32'(mon_state), 32'd0);

        // Five 10-clock pulses: four samples of 10.
        period_ready = 1'b1;
        en = 1'b1;
        tick();
        check("armed_state", 32'(mon_state), 32'd1);
        samp0 = n_samp;
        exp_period = 16'd10;
        repeat (5) pulse(4, 6, 1'b1);
        check("t1_pos", step_pos, 32'd5);
        check("t1_cnt", step_cnt, 32'd5);
        check("t1_nsamp", 32'(n_samp - samp0), 32'd4);
        check("t1_state", 32'(mon_state), 32'd2);

        // One-clock glitch is filtered out.
        samp0 = n_samp;
        pul_in = 1'b1;
        tick();
        pul_in = 1'b0;
        repeat (6) tick();
        check("glitch_pos", step_pos, 32'd5);
        check("glitch_cnt", step_cnt, 32'd5);
        check("glitch_nsamp", 32'(n_samp - samp0), 32'd0);

        // Back-pressure: first sample kept, later ones dropped.
        period_ready = 1'b0;
        en = 1'b0;
        tick();
        check("t3_idle", 32'(mon_state), 32'd0);
        en = 1'b1;
        tick();
        check("t3_armed", 32'(mon_state), 32'd1);
        check("t3_cnt_clr", step_cnt, 32'd0);
        repeat (4) pulse(4, 16, 1'b1);
        check("t3_pvld", 32'(period_valid), 32'd1);
        check("t3_pdata", 32'(period_data), 32'd20);
        check("t3_povf", 32'(period_ovf), 32'd1);
        check("t3_cnt", step_cnt, 32'd4);
        check("t3_pos", step_pos, 32'd9);
        exp_period = 16'd20;
        period_ready = 1'b1;
        tick();
        check("t3_drain_vld", 32'(period_valid), 32'd0);
        check("t3_ovf_sticky", 32'(period_ovf), 32'd1);

        // Stall exactly 50 clocks after the counter loads 1.
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        check("t4_ovf_clr", 32'(period_ovf), 32'd0);
        check("t4_armed", 32'(mon_state), 32'd1);
        dir_in = 1'b1;
        pul_in = 1'b1;
        repeat (4) tick();
        pul_in = 1'b0;
        check("t4_run", 32'(mon_state), 32'd2);
        repeat (49) tick();
        check("t4_prestall_state", 32'(mon_state), 32'd2);
        check("t4_prestall_stall", 32'(stall), 32'd0);
        tick();
        check("t4_stall_state", 32'(mon_state), 32'd3);
        check("t4_stall", 32'(stall), 32'd1);
        samp0 = n_samp;
        pulse(4, 6, 1'b1);
        check("t4_resume_stall", 32'(stall), 32'd0);
        check("t4_resume_state", 32'(mon_state), 32'd2);
        check("t4_resume_nsamp", 32'(n_samp - samp0), 32'd0);
        exp_period = 16'd10;
        pulse(4, 6, 1'b1);
        check("t4_next_nsamp", 32'(n_samp - samp0), 32'd1);
        check("t4_cnt", step_cnt, 32'd3);

        // done at the third step, held through the fourth, cleared by en=0.
        target = 32'd3;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        repeat (2) pulse(4, 6, 1'b1);
        check("t5_done_early", 32'(done), 32'd0);
        pulse(4, 6, 1'b1);
        check("t5_done_set", 32'(done), 32'd1);
        check("t5_cnt3", step_cnt, 32'd3);
        pulse(4, 6, 1'b1);
        check("t5_done_hold", 32'(done), 32'd1);
        check("t5_cnt4", step_cnt, 32'd4);
        check("t5_pos", step_pos, 32'd16);
        en = 1'b0;
        tick();
        check("t5_done_clr", 32'(done), 32'd0);
        check("t5_idle", 32'(mon_state), 32'd0);
        target = 32'd0;

        // pos_clr beats a coincident step, then a reverse step wraps.
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        check("clr_pos", step_pos, 32'd0);
        repeat (7) pulse(4, 6, 1'b1);
        check("pos7", step_pos, 32'd7);
        dir_in = 1'b1;
        pul_in = 1'b1;
        repeat (3) tick();
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        check("clr_coinc", step_pos, 32'd0);
        tick();
        pul_in = 1'b0;
        repeat (6) tick();
        check("clr_coinc_after", step_pos, 32'd0);
        pulse(4, 6, 1'b0);
        check("wrap_neg", step_pos, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of RUN with a pending sample.
        en = 1'b1;
        tick();
        period_ready = 1'b0;
        pulse(4, 6, 1'b1);
        pulse(4, 6, 1'b1);
        check("prerst_vld", 32'(period_valid), 32'd1);
        check("prerst_state", 32'(mon_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
